sram_ctrl: RTL and testbench

- Responder end of the on-chip SRAM request interface. Accepts single-word read/write requests from one client (e.g. the rx/tx queue) and runs them on an external asynchronous 256Kx16 SRAM.
- Performs the chip-enable / output-enable / write-enable pin sequencing with programmable wait states, and returns read data with a one-cycle valid strobe.
- Sits between the queue logic and the top-level tristate pad instance.

---
 rtl/sram_ctrl_pkg.sv | 61 ++++++
 rtl/sram_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry/timing for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W  = 18;
    localparam int unsigned SRAM_DATA_W  = 16;
    localparam int unsigned SRAM_BE_W    = 2;
    localparam int unsigned SRAM_RD_WAIT = 2;
    localparam int unsigned SRAM_WR_WAIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
        logic dq_oe;
    } pins_t;

    localparam pins_t PINS_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                    lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

    // Pin levels for the cycle spent in a given state.
    function automatic pins_t pins_for(input state_t st, input logic [SRAM_BE_W-1:0] be);
        pins_t p;
        p = PINS_IDLE;
        case (st)
            ST_RD: begin
                p.ce_n = 1'b0;
                p.oe_n = 1'b0;
                p.lb_n = ~be[0];
                p.ub_n = ~be[1];
            end
            ST_WR_SETUP: begin
                p.ce_n  = 1'b0;
                p.dq_oe = 1'b1;
            end
            ST_WR_PULSE: begin
                p.ce_n  = 1'b0;
                p.we_n  = 1'b0;
                p.lb_n  = ~be[0];
                p.ub_n  = ~be[1];
                p.dq_oe = 1'b1;
            end
            ST_WR_HOLD: begin
                p.ce_n  = 1'b0;
                p.dq_oe = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-word request responder driving an external asynchronous 256Kx16 SRAM
// with programmable read/write wait states and registered, glitch-free pins.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = SRAM_ADDR_W,
    parameter int unsigned DATA_W  = SRAM_DATA_W,
    parameter int unsigned RD_WAIT = SRAM_RD_WAIT,
    parameter int unsigned WR_WAIT = SRAM_WR_WAIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sram_req,
    input  logic                 sram_rd,
    input  logic [SRAM_BE_W-1:0] sram_be,
    input  logic [ADDR_W-1:0]    sram_addr,
    input  logic [DATA_W-1:0]    sram_wr_data,
    output logic                 sram_ready,
    output logic [DATA_W-1:0]    sram_rd_data,
    output logic                 sram_rd_data_vld,
    output logic [ADDR_W-1:0]    mem_a,
    output logic [DATA_W-1:0]    mem_dq_o,
    output logic                 mem_dq_oe,
    input  logic [DATA_W-1:0]    mem_dq_i,
    output logic                 mem_ce_n,
    output logic                 mem_oe_n,
    output logic                 mem_we_n,
    output logic                 mem_lb_n,
    output logic                 mem_ub_n
);

    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SRAM_BE_W-1:0] be_q, be_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    dq_o_q, dq_o_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 vld_q, vld_d;
    pins_t                pins_q, pins_d;
    logic                 accept;

    assign accept     = sram_req && (state_q == ST_IDLE);
    assign sram_ready = accept;

    // Next state, captured request fields and next pin levels.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        be_d      = be_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        rd_data_d = rd_data_q;
        vld_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = sram_addr;
                    be_d   = sram_be;
                    if (sram_rd) begin
                        state_d = ST_RD;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                    end else begin
                        state_d = ST_WR_SETUP;
                        dq_o_d  = sram_wr_data;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    rd_data_d = mem_dq_i;
                    vld_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = CNT_W'(WR_WAIT - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins are registered from the next state so each state's levels appear in its own cycle.
        pins_d = pins_for(state_d, be_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            be_q      <= '0;
            addr_q    <= '0;
            dq_o_q    <= '0;
            rd_data_q <= '0;
            vld_q     <= 1'b0;
            pins_q    <= PINS_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            dq_o_q    <= dq_o_d;
            rd_data_q <= rd_data_d;
            vld_q     <= vld_d;
            pins_q    <= pins_d;
        end
    end

    assign sram_rd_data     = rd_data_q;
    assign sram_rd_data_vld = vld_q;
    assign mem_a            = addr_q;
    assign mem_dq_o         = dq_o_q;
    assign mem_dq_oe        = pins_q.dq_oe;
    assign mem_ce_n         = pins_q.ce_n;
    assign mem_oe_n         = pins_q.oe_n;
    assign mem_we_n         = pins_q.we_n;
    assign mem_lb_n         = pins_q.lb_n;
    assign mem_ub_n         = pins_q.ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed requests against a behavioural
// 256Kx16 SRAM, with expected read data queued at accept time.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sram_req;
    logic        sram_rd;
    logic [1:0]  sram_be;
    logic [17:0] sram_addr;
    logic [15:0] sram_wr_data;
    logic        sram_ready;
    logic [15:0] sram_rd_data;
    logic        sram_rd_data_vld;
    logic [17:0] mem_a;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [15:0] mem_dq_i;
    logic        mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;

    sram_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sram_req         (sram_req),
        .sram_rd          (sram_rd),
        .sram_be          (sram_be),
        .sram_addr        (sram_addr),
        .sram_wr_data     (sram_wr_data),
        .sram_ready       (sram_ready),
        .sram_rd_data     (sram_rd_data),
        .sram_rd_data_vld (sram_rd_data_vld),
        .mem_a            (mem_a),
        .mem_dq_o         (mem_dq_o),
        .mem_dq_oe        (mem_dq_oe),
        .mem_dq_i         (mem_dq_i),
        .mem_ce_n         (mem_ce_n),
        .mem_oe_n         (mem_oe_n),
        .mem_we_n         (mem_we_n),
        .mem_lb_n         (mem_lb_n),
        .mem_ub_n         (mem_ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte writes while we_n is low, data out while oe_n is low.
    logic [15:0] mem [0:(1<<18)-1];
    assign mem_dq_i = (!mem_ce_n && !mem_oe_n) ? mem[mem_a] : 16'h0000;
    always @(posedge clk) begin
        if (!mem_ce_n && !mem_we_n && mem_dq_oe) begin
            if (!mem_lb_n) mem[mem_a][7:0]  <= mem_dq_o[7:0];
            if (!mem_ub_n) mem[mem_a][15:8] <= mem_dq_o[15:8];
        end
    end

    typedef struct {
        logic        care;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int n_issue = 0;
    int acc_cnt = 0, vld_cnt = 0, vld_cyc = 0, wr_done = 0, viol = 0;
    int we_low = 0, oe_low = 0, dq_oe_cnt = 0, lb_low = 0, ub_low = 0;
    logic prev_we_n = 1'b1;

    int aw1, ar1, aw2, ar2, aw3, ar3, ar4, aw4, ar5, awr, aw5, ar6;
    int s_we, s_oe, s_dq, s_lb, s_ub, s_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pin statistics, protocol invariants and read-data scoreboard.
    initial forever begin
        @(negedge clk);
        if (sram_ready && sram_req) acc_cnt++;
        if ((sram_ready && !sram_req) || (!mem_oe_n && mem_dq_oe) ||
            (!mem_oe_n && !mem_we_n) || (!mem_we_n && !mem_dq_oe)) viol++;
        if (!mem_we_n) we_low++;
        if (!mem_oe_n) oe_low++;
        if (mem_dq_oe) dq_oe_cnt++;
        if (!mem_lb_n) lb_low++;
        if (!mem_ub_n) ub_low++;
        if (!prev_we_n && mem_we_n) wr_done++;
        prev_we_n = mem_we_n;
        if (sram_rd_data_vld) begin
            vld_cnt++;
            vld_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("rd_vld_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.care) chk("rd_data", 32'(sram_rd_data), 32'(e.data));
            end
        end
    end

    // Present a request, wait for its accept, check the first access cycle's pins.
    task automatic issue(input logic rd, input logic [17:0] a, input logic [1:0] be,
                         input logic [15:0] d, input logic care, input logic [15:0] exp,
                         output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        sram_req = 1'b1; sram_rd = rd; sram_be = be; sram_addr = a; sram_wr_data = d;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (sram_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            sram_req = 1'b0;
            return;
        end
        n_issue++;
        if (rd) exp_q.push_back('{care: care, data: exp});
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_busy", 32'(sram_ready), 32'd0);
        chk("ce_n_first", 32'(mem_ce_n), 32'd0);
        chk("oe_n_first", 32'(mem_oe_n), 32'(!rd));
        chk("dq_oe_first", 32'(mem_dq_oe), 32'(!rd));
        chk("we_n_first", 32'(mem_we_n), 32'd1);
        chk("mem_a", 32'(mem_a), 32'(a));
        if (!rd) chk("dq_o", 32'(mem_dq_o), 32'(d));
        @(posedge clk); #1;
        sram_req     = 1'b0;
        sram_rd      = 1'($urandom);
        sram_be      = 2'($urandom);
        sram_addr    = 18'($urandom);
        sram_wr_data = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; sram_req = 1'b0; sram_rd = 1'b0; sram_be = 2'b00;
        sram_addr = '0; sram_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}), 32'h1F);
        chk("rst_dq_oe", 32'(mem_dq_oe), 32'd0);
        chk("rst_ready", 32'(sram_ready), 32'd0);
        chk("rst_vld", 32'(sram_rd_data_vld), 32'd0);
        chk("rst_rd_data", 32'(sram_rd_data), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_dq_o", 32'(mem_dq_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write, read-back, then a be=01 write issued in the read's vld cycle.
        s_we = we_low; s_oe = oe_low; s_dq = dq_oe_cnt; s_lb = lb_low; s_ub = ub_low;
        issue(1'b0, 18'h00005, 2'b11, 16'h1234, 1'b0, 16'h0000, aw1);
        issue(1'b1, 18'h00005, 2'b11, 16'h0000, 1'b1, 16'h1234, ar1);
        issue(1'b0, 18'h00005, 2'b01, 16'hABCD, 1'b0, 16'h0000, aw2);
        drain();
        chk("wr_to_rd_accept_gap", 32'(ar1 - aw1), 32'd5);
        chk("rd_vld_latency", 32'(vld_cyc - ar1), 32'd3);
        chk("rd_to_wr_accept_gap", 32'(aw2 - ar1), 32'd3);
        chk("we_low_cycles", 32'(we_low - s_we), 32'd4);
        chk("oe_low_cycles", 32'(oe_low - s_oe), 32'd2);
        chk("dq_oe_cycles", 32'(dq_oe_cnt - s_dq), 32'd8);
        chk("lb_low_cycles", 32'(lb_low - s_lb), 32'd6);
        chk("ub_low_cycles", 32'(ub_low - s_ub), 32'd4);
        chk("rd_data_hold", 32'(sram_rd_data), 32'h1234);

        // Merged read-back, then a be=00 write that must not touch memory.
        s_we = we_low; s_lb = lb_low; s_ub = ub_low;
        issue(1'b1, 18'h00005, 2'b11, 16'h0000, 1'b1, 16'h12CD, ar2);
        issue(1'b0, 18'h00005, 2'b00, 16'hFFFF, 1'b0, 16'h0000, aw3);
        drain();
        chk("be00_we_low", 32'(we_low - s_we), 32'd2);
        chk("be00_lb_low", 32'(lb_low - s_lb), 32'd2);
        chk("be00_ub_low", 32'(ub_low - s_ub), 32'd2);

        issue(1'b1, 18'h00005, 2'b11, 16'h0000, 1'b1, 16'h12CD, ar3);
        issue(1'b1, 18'h00005, 2'b00, 16'h0000, 1'b0, 16'h0000, ar4);
        issue(1'b0, 18'h3FFFF, 2'b11, 16'hBEEF, 1'b0, 16'h0000, aw4);
        issue(1'b1, 18'h3FFFF, 2'b11, 16'h0000, 1'b1, 16'hBEEF, ar5);
        drain();
        chk("rd_rd_accept_gap", 32'(ar4 - ar3), 32'd3);

        // Idle with no request.
        repeat (5) @(posedge clk);
        #1;

        // Reset during the write pulse aborts the access.
        s_vld = vld_cnt;
        issue(1'b0, 18'h00009, 2'b11, 16'h0F0F, 1'b0, 16'h0000, awr);
        chk("we_n_in_pulse", 32'(mem_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we_n", 32'(mem_we_n), 32'd1);
        chk("rst_async_ce_n", 32'(mem_ce_n), 32'd1);
        chk("rst_async_dq_oe", 32'(mem_dq_oe), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_vld", 32'(vld_cnt - s_vld), 32'd0);

        issue(1'b0, 18'h00007, 2'b11, 16'h5A5A, 1'b0, 16'h0000, aw5);
        issue(1'b1, 18'h00007, 2'b11, 16'h0000, 1'b1, 16'h5A5A, ar6);
        drain();

        chk("accepts_vs_issued", 32'(acc_cnt), 32'(n_issue));
        // One write was aborted by reset and never completes.
        chk("completions", 32'(vld_cnt + wr_done), 32'(n_issue - 1));
        chk("protocol_violations", 32'(viol), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
